l15_req_arbiter: RTL and testbench
==================================

L15_REQ_ARBITER -- requirements
Module: l15_req_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 40, L1.5 address width; DATA_W, 64, L1.5 data word width; STREAK_MAX, 4, consecutive data grants tolerated while fetch waits.
REQ-002 Clock and reset SHALL be: clk in 1 clock; nrst in 1 reset, asynchronous, active-low.
REQ-003 Fetch request port (suffix _i) SHALL be: i_rqtype in 5; i_size in 3; i_address in ADDR_W; i_data in DATA_W; i_val in 1 request valid; i_req_ack in 1 fetch accepts response.
REQ-004 Data request port (suffix _d) SHALL mirror REQ-003: d_rqtype, d_size, d_address, d_data, d_val, d_req_ack.
REQ-005 Fetch response port SHALL be: i_header_ack out 1; i_resp_val out 1; i_ack out 1.
REQ-006 Data response port SHALL be: d_header_ack out 1; d_resp_val out 1; d_ack out 1.
REQ-007 Shared response buses SHALL be: resp_data_0 out DATA_W; resp_data_1 out DATA_W; resp_returntype out 4; all driven from L1.5 regardless of owner.
REQ-008 L1.5 side SHALL be: transducer_l15_rqtype out 5; _size out 3; _address out ADDR_W; _data out DATA_W; _val out 1; transducer_l15_req_ack out 1; l15_transducer_ack, _header_ack, _val in 1; l15_transducer_data_0/_1 in DATA_W; l15_transducer_returntype in 4.
REQ-009 Status SHALL be: arb_busy out 1 (state != IDLE); arb_owner_d out 1 (1 = data owns bus).

Function
REQ-010 FSM SHALL have states IDLE, REQ, RESP; one transaction outstanding at a time.
REQ-011 IDLE: if i_val or d_val, owner SHALL be registered and state SHALL go REQ next cycle; transducer_l15_val SHALL be 0 in IDLE.
REQ-012 Arbitration: data SHALL win when both valid, except per REQ-024.
REQ-013 REQ: all transducer_l15_* request fields and _val SHALL be the owner's inputs, combinationally muxed; non-owner fields SHALL never appear.
REQ-014 REQ: l15_transducer_header_ack SHALL be routed to owner's header_ack only; on it state SHALL go RESP next cycle.
REQ-015 REQ: if owner's val drops before header_ack, state SHALL return to IDLE with no response routing.
REQ-016 RESP: transducer_l15_val SHALL be 0; l15_transducer_val SHALL drive owner's resp_val; l15_transducer_ack SHALL drive owner's ack; transducer_l15_req_ack SHALL equal owner's req_ack.
REQ-017 RESP SHALL exit to IDLE when (l15_transducer_val and owner req_ack) or l15_transducer_ack; no response during REQ is forwarded.
REQ-018 Non-owner header_ack, resp_val, ack SHALL be 0 in every state.
REQ-019 In IDLE and REQ, transducer_l15_req_ack SHALL be 0 and l15_transducer_val SHALL be ignored.
REQ-020 Minimum transaction: request at cycle 0 -> L1.5 val at cycle 1 -> IDLE reentered the cycle after response handshake; back-to-back requests SHALL incur one IDLE cycle.

Reset
REQ-021 On nrst low, state SHALL be IDLE, owner 0, streak counter 0, asynchronously.
REQ-022 During and after reset all outputs SHALL be 0 (buses 0); reset mid-transaction SHALL abandon it without routing any further response.

Configuration
REQ-023 Macro L15_ARB_FAIRNESS_EN SHALL select fairness logic.
REQ-024 With L15_ARB_FAIRNESS_EN: saturating counter of consecutive data grants while i_val high; when it equals STREAK_MAX and i_val high, fetch SHALL win; counter SHALL clear on any fetch grant.
REQ-025 Without it: fixed data priority, no counter.

Structure
REQ-026 Shared package SHALL hold state enum (IDLE=0, REQ=1, RESP=2), owner encoding, L1.5 rqtype/returntype constants.
REQ-027 Single module; optional sub-module l15_arb_fair_cnt for the streak counter.

Verification
REQ-028 i_val alone, addr 0x00_0000_1000 -> L1.5 val cycle 1 with that address; header_ack -> i_header_ack; l15_val with data_0=0xDEAD -> i_resp_val, d_resp_val=0.
REQ-029 i_val and d_val same cycle -> data granted first, fetch granted after data RESP completes plus one IDLE cycle.
REQ-030 Fairness on, STREAK_MAX=4, d_val and i_val held -> grants D,D,D,D,I; fairness off -> D only.
REQ-031 d_val drops in REQ before header_ack -> IDLE next cycle, no header_ack to either port.
REQ-032 nrst pulsed in RESP -> IDLE, all outputs 0; subsequent l15_transducer_val routed nowhere.

Source files
------------

// File: rtl/l15_req_arbiter_pkg.sv
// Shared types and constants for the L1.5 request arbiter.
// State encoding, bus-owner encoding and the L1.5 request/return type codes
// used by the arbiter and its clients.
package l15_req_arbiter_pkg;

    // Arbiter FSM states; encodings are visible on the arb_state debug port.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Which client currently owns the L1.5 request/response path.
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

    // L1.5 request types.
    localparam logic [4:0] L15_RQTYPE_LOAD  = 5'b00000;
    localparam logic [4:0] L15_RQTYPE_STORE = 5'b00001;
    localparam logic [4:0] L15_RQTYPE_IMISS = 5'b10000;

    // L1.5 return types.
    localparam logic [3:0] L15_RET_LOAD   = 4'b0000;
    localparam logic [3:0] L15_RET_IFILL  = 4'b0001;
    localparam logic [3:0] L15_RET_ST_ACK = 4'b0100;

    // True when the data client owns the bus.
    function automatic logic owner_is_data(input arb_owner_t owner);
        return owner == OWNER_D;
    endfunction

endpackage

// File: rtl/l15_req_arbiter_if.sv
// One client port of the L1.5 arbiter: request fields plus its private
// response strobes.
// Handshake: the client holds val and the request fields stable until the
// arbiter returns header_ack; dropping val before header_ack withdraws the
// request. After header_ack the client sees resp_val/ack only while it owns
// the bus, and raises req_ack to accept a resp_val beat.
interface l15_req_arbiter_if #(
    parameter int ADDR_W = 40,
    parameter int DATA_W = 64
) ();

    logic [4:0]        rqtype;
    logic [2:0]        size;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic              val;
    logic              req_ack;
    logic              header_ack;
    logic              resp_val;
    logic              ack;

    // Client side: drives the request, receives the response strobes.
    modport master (
        output rqtype, size, address, data, val, req_ack,
        input  header_ack, resp_val, ack
    );

    // Arbiter side.
    modport slave (
        input  rqtype, size, address, data, val, req_ack,
        output header_ack, resp_val, ack
    );

endinterface

// File: rtl/l15_arb_fair_cnt.sv
// Streak counter for the L1.5 arbiter fairness option.
// Counts consecutive data grants made while the fetch client is waiting,
// saturating at STREAK_MAX; once saturated and fetch still waits, the next
// grant is forced to fetch. Any fetch grant clears the streak.
module l15_arb_fair_cnt #(
    parameter int STREAK_MAX = 4,
    parameter int CNT_W      = $clog2(STREAK_MAX + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             grant_d,
    input  logic             grant_i,
    input  logic             fetch_wait,
    output logic             force_fetch,
    output logic [CNT_W-1:0] streak
);

    localparam logic [CNT_W-1:0] STREAK_SAT = CNT_W'(STREAK_MAX);

    // Track consecutive data grants that left fetch waiting.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            streak <= '0;
        end else if (grant_i) begin
            streak <= '0;
        end else if (grant_d) begin
            if (!fetch_wait) begin
                streak <= '0;
            end else if (streak != STREAK_SAT) begin
                streak <= streak + 1'b1;
            end
        end
    end

    assign force_fetch = fetch_wait && (streak == STREAK_SAT);

endmodule

// File: rtl/l15_req_arbiter.sv
// L1.5 request arbiter: shares one L1.5 transducer port between a fetch
// client and a data client, one transaction at a time.
// IDLE picks an owner (data has priority), REQ forwards the owner's request
// until L1.5 header_ack, RESP forwards L1.5 response strobes to the owner
// until the response handshake completes.
// Build option: define L15_ARB_FAIRNESS_EN to let a waiting fetch win after
// STREAK_MAX consecutive data grants; otherwise data priority is fixed.
module l15_req_arbiter
    import l15_req_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 40,
    parameter int DATA_W     = 64,
    parameter int STREAK_MAX = 4
) (
    input  logic                              clk,
    input  logic                              nrst,

    l15_req_arbiter_if.slave                  fetch,
    l15_req_arbiter_if.slave                  data,

    output logic [DATA_W-1:0]                 resp_data_0,
    output logic [DATA_W-1:0]                 resp_data_1,
    output logic [3:0]                        resp_returntype,

    output logic [4:0]                        transducer_l15_rqtype,
    output logic [2:0]                        transducer_l15_size,
    output logic [ADDR_W-1:0]                 transducer_l15_address,
    output logic [DATA_W-1:0]                 transducer_l15_data,
    output logic                              transducer_l15_val,
    output logic                              transducer_l15_req_ack,
    input  logic                              l15_transducer_ack,
    input  logic                              l15_transducer_header_ack,
    input  logic                              l15_transducer_val,
    input  logic [DATA_W-1:0]                 l15_transducer_data_0,
    input  logic [DATA_W-1:0]                 l15_transducer_data_1,
    input  logic [3:0]                        l15_transducer_returntype,

    output logic                              arb_busy,
    output logic                              arb_owner_d,
    output arb_state_t                        arb_state,
    output logic [$clog2(STREAK_MAX+1)-1:0]   arb_streak
);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q, owner_d;
    logic       force_fetch;

    logic [4:0]        own_rqtype;
    logic [2:0]        own_size;
    logic [ADDR_W-1:0] own_address;
    logic [DATA_W-1:0] own_data;
    logic              own_val;
    logic              own_req_ack;

`ifdef L15_ARB_FAIRNESS_EN
    logic grant_d;
    logic grant_i;

    // A grant is the IDLE -> REQ transition; the new owner says which client.
    assign grant_d = (state_q == IDLE) && (state_d == REQ) && (owner_d == OWNER_D);
    assign grant_i = (state_q == IDLE) && (state_d == REQ) && (owner_d == OWNER_I);

    l15_arb_fair_cnt #(
        .STREAK_MAX (STREAK_MAX),
        .CNT_W      ($clog2(STREAK_MAX+1))
    ) u_fair_cnt (
        .clk         (clk),
        .nrst        (nrst),
        .grant_d     (grant_d),
        .grant_i     (grant_i),
        .fetch_wait  (fetch.val),
        .force_fetch (force_fetch),
        .streak      (arb_streak)
    );
`else
    // Fixed data priority: fetch is never forced and no streak is kept.
    assign force_fetch = 1'b0;
    assign arb_streak  = '0;
`endif

    // State and owner registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            owner_q <= OWNER_I;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Next-state logic: grant in IDLE, wait for header_ack in REQ, wait for
    // the response handshake in RESP.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (data.val && !force_fetch) begin
                    owner_d = OWNER_D;
                    state_d = REQ;
                end else if (fetch.val) begin
                    owner_d = OWNER_I;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!own_val) begin
                    state_d = IDLE;
                end else if (l15_transducer_header_ack) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if ((l15_transducer_val && own_req_ack) || l15_transducer_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Select the owning client's request fields.
    always_comb begin
        own_rqtype  = fetch.rqtype;
        own_size    = fetch.size;
        own_address = fetch.address;
        own_data    = fetch.data;
        own_val     = fetch.val;
        own_req_ack = fetch.req_ack;
        if (owner_q == OWNER_D) begin
            own_rqtype  = data.rqtype;
            own_size    = data.size;
            own_address = data.address;
            own_data    = data.data;
            own_val     = data.val;
            own_req_ack = data.req_ack;
        end
    end

    // Drive the L1.5 request side only while a request is being presented.
    always_comb begin
        transducer_l15_rqtype  = '0;
        transducer_l15_size    = '0;
        transducer_l15_address = '0;
        transducer_l15_data    = '0;
        transducer_l15_val     = 1'b0;
        transducer_l15_req_ack = 1'b0;
        if (state_q == REQ) begin
            transducer_l15_rqtype  = own_rqtype;
            transducer_l15_size    = own_size;
            transducer_l15_address = own_address;
            transducer_l15_data    = own_data;
            transducer_l15_val     = own_val;
        end
        if (state_q == RESP) begin
            transducer_l15_req_ack = own_req_ack;
        end
    end

    // Route L1.5 strobes to the owner only; the other client always sees 0.
    always_comb begin
        fetch.header_ack = 1'b0;
        fetch.resp_val   = 1'b0;
        fetch.ack        = 1'b0;
        data.header_ack  = 1'b0;
        data.resp_val    = 1'b0;
        data.ack         = 1'b0;
        if (state_q == REQ) begin
            if (owner_q == OWNER_D) begin
                data.header_ack  = l15_transducer_header_ack;
            end else begin
                fetch.header_ack = l15_transducer_header_ack;
            end
        end
        if (state_q == RESP) begin
            if (owner_q == OWNER_D) begin
                data.resp_val  = l15_transducer_val;
                data.ack       = l15_transducer_ack;
            end else begin
                fetch.resp_val = l15_transducer_val;
                fetch.ack      = l15_transducer_ack;
            end
        end
    end

    // Shared response buses follow L1.5 directly but read as 0 while in reset.
    always_comb begin
        resp_data_0     = '0;
        resp_data_1     = '0;
        resp_returntype = '0;
        if (nrst) begin
            resp_data_0     = l15_transducer_data_0;
            resp_data_1     = l15_transducer_data_1;
            resp_returntype = l15_transducer_returntype;
        end
    end

    assign arb_busy    = (state_q != IDLE);
    assign arb_owner_d = owner_is_data(owner_q);
    assign arb_state   = state_q;

endmodule

// File: tb/tb_l15_req_arbiter.sv
// Directed bench for l15_req_arbiter. Honours L15_ARB_FAIRNESS_EN when the
// same macro is defined for the build.
module tb_l15_req_arbiter;
    import l15_req_arbiter_pkg::*;

    localparam int ADDR_W     = 40;
    localparam int DATA_W     = 64;
    localparam int STREAK_MAX = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic nrst;
    always #5 clk = ~clk;

    l15_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) fetch_if ();
    l15_req_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) data_if ();

    logic [DATA_W-1:0] resp_data_0;
    logic [DATA_W-1:0] resp_data_1;
    logic [3:0]        resp_returntype;
    logic [4:0]        transducer_l15_rqtype;
    logic [2:0]        transducer_l15_size;
    logic [ADDR_W-1:0] transducer_l15_address;
    logic [DATA_W-1:0] transducer_l15_data;
    logic              transducer_l15_val;
    logic              transducer_l15_req_ack;
    logic              l15_transducer_ack;
    logic              l15_transducer_header_ack;
    logic              l15_transducer_val;
    logic [DATA_W-1:0] l15_transducer_data_0;
    logic [DATA_W-1:0] l15_transducer_data_1;
    logic [3:0]        l15_transducer_returntype;
    logic              arb_busy;
    logic              arb_owner_d;
    arb_state_t        arb_state;
    logic [2:0]        arb_streak;

    l15_req_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .STREAK_MAX (STREAK_MAX)
    ) dut (
        .clk                       (clk),
        .nrst                      (nrst),
        .fetch                     (fetch_if.slave),
        .data                      (data_if.slave),
        .resp_data_0               (resp_data_0),
        .resp_data_1               (resp_data_1),
        .resp_returntype           (resp_returntype),
        .transducer_l15_rqtype     (transducer_l15_rqtype),
        .transducer_l15_size       (transducer_l15_size),
        .transducer_l15_address    (transducer_l15_address),
        .transducer_l15_data       (transducer_l15_data),
        .transducer_l15_val        (transducer_l15_val),
        .transducer_l15_req_ack    (transducer_l15_req_ack),
        .l15_transducer_ack        (l15_transducer_ack),
        .l15_transducer_header_ack (l15_transducer_header_ack),
        .l15_transducer_val        (l15_transducer_val),
        .l15_transducer_data_0     (l15_transducer_data_0),
        .l15_transducer_data_1     (l15_transducer_data_1),
        .l15_transducer_returntype (l15_transducer_returntype),
        .arb_busy                  (arb_busy),
        .arb_owner_d               (arb_owner_d),
        .arb_state                 (arb_state),
        .arb_streak                (arb_streak)
    );

    // ---------------- scoreboard counters ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fetch_if.rqtype  = '0; fetch_if.size = '0; fetch_if.address = '0;
        fetch_if.data    = '0; fetch_if.val  = 1'b0; fetch_if.req_ack = 1'b0;
        data_if.rqtype   = '0; data_if.size  = '0; data_if.address  = '0;
        data_if.data     = '0; data_if.val   = 1'b0; data_if.req_ack  = 1'b0;
        l15_transducer_ack        = 1'b0;
        l15_transducer_header_ack = 1'b0;
        l15_transducer_val        = 1'b0;
        l15_transducer_data_0     = '0;
        l15_transducer_data_1     = '0;
        l15_transducer_returntype = '0;
    endtask

    // One complete transaction with both clients requesting; checks who won.
    task automatic run_grant(input int k, input logic exp_d);
        chk($sformatf("g%0d_idle", k), arb_state, IDLE);
        nxt();
        chk($sformatf("g%0d_req", k), arb_state, REQ);
        chk($sformatf("g%0d_owner", k), arb_owner_d, exp_d);
        chk($sformatf("g%0d_addr", k), transducer_l15_address,
            exp_d ? 40'h12_3456_7000 : 40'h00_0000_2000);
        l15_transducer_header_ack = 1'b1;
        nxt();
        l15_transducer_header_ack = 1'b0;
        chk($sformatf("g%0d_resp", k), arb_state, RESP);
        l15_transducer_ack = 1'b1;
        #1;
        chk($sformatf("g%0d_ack", k), exp_d ? data_if.ack : fetch_if.ack, 1'b1);
        chk($sformatf("g%0d_other_ack", k), exp_d ? fetch_if.ack : data_if.ack, 1'b0);
        nxt();
        l15_transducer_ack = 1'b0;
        #1;
    endtask

    logic [4:0] exp_grants;

    initial begin
`ifdef L15_ARB_FAIRNESS_EN
        exp_grants = 5'b01111;   // bit k = grant k went to data: D,D,D,D,I
`else
        exp_grants = 5'b11111;   // data every time
`endif
        // ---------------- reset, with every input active ----------------
        nrst = 1'b0;
        clear_inputs();
        fetch_if.val = 1'b1; data_if.val = 1'b1;
        l15_transducer_val = 1'b1; l15_transducer_ack = 1'b1;
        l15_transducer_header_ack = 1'b1;
        l15_transducer_data_0 = 64'hAAAA; l15_transducer_returntype = 4'h5;
        nxt(); nxt();
        chk("rst_state", arb_state, IDLE);
        chk("rst_busy", arb_busy, 1'b0);
        chk("rst_owner", arb_owner_d, 1'b0);
        chk("rst_streak", arb_streak, 3'd0);
        chk("rst_tl_val", transducer_l15_val, 1'b0);
        chk("rst_tl_addr", transducer_l15_address, '0);
        chk("rst_req_ack", transducer_l15_req_ack, 1'b0);
        chk("rst_resp_data0", resp_data_0, '0);
        chk("rst_returntype", resp_returntype, '0);
        chk("rst_strobes", {fetch_if.header_ack, fetch_if.resp_val, fetch_if.ack,
                            data_if.header_ack, data_if.resp_val, data_if.ack}, 6'b0);
        clear_inputs();
        nrst = 1'b1;
        nxt();

        // ---------------- fetch alone ----------------
        fetch_if.val = 1'b1; fetch_if.address = 40'h00_0000_1000;
        fetch_if.rqtype = L15_RQTYPE_IMISS; fetch_if.size = 3'b111;
        data_if.address = 40'h00_0000_BEEF; data_if.rqtype = L15_RQTYPE_STORE;
        #1;
        chk("f_idle_val", transducer_l15_val, 1'b0);
        nxt();
        chk("f_req_state", arb_state, REQ);
        chk("f_tl_val", transducer_l15_val, 1'b1);
        chk("f_tl_addr", transducer_l15_address, 40'h00_0000_1000);
        chk("f_tl_rqtype", transducer_l15_rqtype, L15_RQTYPE_IMISS);
        chk("f_tl_size", transducer_l15_size, 3'b111);
        chk("f_req_ack_req", transducer_l15_req_ack, 1'b0);
        l15_transducer_header_ack = 1'b1;
        #1;
        chk("f_i_hdr", fetch_if.header_ack, 1'b1);
        chk("f_d_hdr", data_if.header_ack, 1'b0);
        nxt();
        l15_transducer_header_ack = 1'b0; fetch_if.val = 1'b0;
        chk("f_resp_state", arb_state, RESP);
        chk("f_resp_tl_val", transducer_l15_val, 1'b0);
        l15_transducer_val = 1'b1; l15_transducer_data_0 = 64'hDEAD;
        l15_transducer_returntype = L15_RET_IFILL; fetch_if.req_ack = 1'b1;
        #1;
        chk("f_i_resp_val", fetch_if.resp_val, 1'b1);
        chk("f_d_resp_val", data_if.resp_val, 1'b0);
        chk("f_resp_data0", resp_data_0, 64'hDEAD);
        chk("f_returntype", resp_returntype, L15_RET_IFILL);
        chk("f_tl_req_ack", transducer_l15_req_ack, 1'b1);
        nxt();
        clear_inputs();
        #1;
        chk("f_done_state", arb_state, IDLE);
        chk("f_done_busy", arb_busy, 1'b0);

        // ---------------- simultaneous requests ----------------
        fetch_if.val = 1'b1; fetch_if.address = 40'h00_0000_2000;
        data_if.val  = 1'b1; data_if.address  = 40'h12_3456_7000;
        data_if.rqtype = L15_RQTYPE_LOAD;
        nxt();
        chk("b_owner_d", arb_owner_d, 1'b1);
        chk("b_tl_addr_d", transducer_l15_address, 40'h12_3456_7000);
        l15_transducer_header_ack = 1'b1;
        #1;
        chk("b_d_hdr", data_if.header_ack, 1'b1);
        chk("b_i_hdr", fetch_if.header_ack, 1'b0);
        nxt();
        l15_transducer_header_ack = 1'b0; data_if.val = 1'b0;
        l15_transducer_ack = 1'b1;
        #1;
        chk("b_d_ack", data_if.ack, 1'b1);
        chk("b_i_ack", fetch_if.ack, 1'b0);
        nxt();
        l15_transducer_ack = 1'b0;
        #1;
        chk("b_gap_state", arb_state, IDLE);
        chk("b_gap_tl_val", transducer_l15_val, 1'b0);
        nxt();
        chk("b_owner_i", arb_owner_d, 1'b0);
        chk("b_tl_addr_i", transducer_l15_address, 40'h00_0000_2000);
        l15_transducer_header_ack = 1'b1;
        nxt();
        l15_transducer_header_ack = 1'b0; fetch_if.val = 1'b0;
        // Response beat not yet accepted: must stay in RESP.
        l15_transducer_val = 1'b1; fetch_if.req_ack = 1'b0;
        #1;
        chk("b_tl_req_ack0", transducer_l15_req_ack, 1'b0);
        nxt();
        chk("b_hold_resp", arb_state, RESP);
        fetch_if.req_ack = 1'b1;
        nxt();
        clear_inputs();
        #1;
        chk("b_done_state", arb_state, IDLE);

        // ---------------- streak of grants with both requesting ----------------
        fetch_if.val = 1'b1; fetch_if.address = 40'h00_0000_2000;
        data_if.val  = 1'b1; data_if.address  = 40'h12_3456_7000;
        for (int k = 0; k < 5; k++) begin
            run_grant(k, exp_grants[k]);
        end
        clear_inputs();
        nxt();

        // ---------------- data withdraws before header_ack ----------------
        data_if.val = 1'b1; data_if.address = 40'h00_0000_3000;
        nxt();
        chk("w_req_state", arb_state, REQ);
        data_if.val = 1'b0;
        #1;
        chk("w_tl_val", transducer_l15_val, 1'b0);
        nxt();
        chk("w_idle_state", arb_state, IDLE);
        l15_transducer_header_ack = 1'b1;
        #1;
        chk("w_hdr_both", {fetch_if.header_ack, data_if.header_ack}, 2'b00);
        clear_inputs();
        nxt();

        // ---------------- reset during RESP ----------------
        fetch_if.val = 1'b1; fetch_if.address = 40'h00_0000_4000;
        nxt();
        l15_transducer_header_ack = 1'b1;
        nxt();
        l15_transducer_header_ack = 1'b0; fetch_if.val = 1'b0;
        chk("r_resp_state", arb_state, RESP);
        l15_transducer_data_0 = 64'h5555;
        nrst = 1'b0;
        #1;
        chk("r_state", arb_state, IDLE);
        chk("r_busy", arb_busy, 1'b0);
        chk("r_resp_data0", resp_data_0, '0);
        nrst = 1'b1;
        l15_transducer_val = 1'b1; l15_transducer_ack = 1'b1; fetch_if.req_ack = 1'b1;
        #1;
        chk("r_post_strobes", {fetch_if.resp_val, fetch_if.ack, data_if.resp_val, data_if.ack}, 4'b0);
        chk("r_post_req_ack", transducer_l15_req_ack, 1'b0);
        chk("r_post_data0", resp_data_0, 64'h5555);
        nxt();
        chk("r_post_state", arb_state, IDLE);
        clear_inputs();
        nxt();

        // ---------------- final report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
